// File: rtl/dht11_temp_reader.sv
// DHT11 poller: sends the start pulse, decodes the 40-bit reply
// and holds the latest good temperature/humidity reading.
module dht11_temp_reader #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int POLL_US    = 2_000_000,
  parameter int START_US   = 18_000,
  parameter int TIMEOUT_US = 100,
  parameter int BIT_THR_US = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] tem_reg,
  output logic [7:0] hum_reg,
  output logic       data_valid,
  output logic       sensor_err,
  output logic       busy
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, REL, RSP_LO,
    RSP_HI, BIT_LO, BIT_HI, CHECK
  } state_t;

  state_t      state, nxt;
  logic [DW-1:0] div_cnt;
  logic        tick;
  logic        s1, s2, s3;
  logic        rise, fall;
  logic [31:0] timer;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic [7:0]  csum_calc;
  logic        csum_ok;
  logic        waiting;
  logic        to_err, shift, clr_cnt;
  logic        poll_done, start_done;
  logic        late, bit_val;

  assign tick = (div_cnt == DW'(DIV - 1));

  // Free-running 1 us tick divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Two-flop synchroniser plus a delay flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= dht_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign poll_done  = tick && (timer >= 32'(POLL_US - 1));
  assign start_done = tick && (timer >= 32'(START_US - 1));
  assign late       = timer > 32'(TIMEOUT_US);
  // Timer trails the line by one tick when the fall is acted on
  assign bit_val    = timer >= 32'(BIT_THR_US);

  assign csum_calc = shreg[39:32] + shreg[31:24]
                   + shreg[23:16] + shreg[15:8];
  assign csum_ok   = (csum_calc == shreg[7:0]);

  assign waiting = (state == REL) || (state == RSP_LO)
                || (state == RSP_HI) || (state == BIT_LO)
                || (state == BIT_HI);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic with a shared timeout for all wait states
  always_comb begin
    nxt     = state;
    to_err  = 1'b0;
    shift   = 1'b0;
    clr_cnt = 1'b0;
    unique case (state)
      IDLE:   if (poll_done) nxt = START;
      START:  if (start_done) nxt = REL;
      REL:    if (fall) nxt = RSP_LO;
      RSP_LO: if (rise) nxt = RSP_HI;
      RSP_HI: begin
        if (fall) begin
          nxt     = BIT_LO;
          clr_cnt = 1'b1;
        end
      end
      BIT_LO: if (rise) nxt = BIT_HI;
      BIT_HI: begin
        if (fall) begin
          shift = 1'b1;
          nxt   = (bit_cnt == 6'd39) ? CHECK : BIT_LO;
        end
      end
      CHECK:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (waiting && (nxt == state) && late) begin
      nxt    = IDLE;
      to_err = 1'b1;
    end
  end

  // Saturating per-state microsecond timer, cleared on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     timer <= '0;
    else if (nxt != state)         timer <= '0;
    else if (tick && timer != '1)  timer <= timer + 1'b1;
  end

  // Bit capture, result registers and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      tem_reg    <= 8'd24;
      hum_reg    <= 8'd0;
      data_valid <= 1'b0;
      sensor_err <= 1'b0;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      dht_oe     <= (nxt == START);
      busy       <= (nxt != IDLE);
      if (clr_cnt) bit_cnt <= '0;
      if (shift) begin
        shreg   <= {shreg[38:0], bit_val};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == CHECK) begin
        if (csum_ok) begin
          tem_reg    <= shreg[23:16];
          hum_reg    <= shreg[39:32];
          data_valid <= 1'b1;
          sensor_err <= 1'b0;
        end else begin
          sensor_err <= 1'b1;
        end
      end
      if (to_err) sensor_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_temp_reader.sv
// Bench for dht11_temp_reader: a sensor model answers each poll
// and a frame-level reference predicts the held reading.
module tb_dht11_temp_reader;

  localparam int THR = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] tem_reg;
  logic [7:0] hum_reg;
  logic       data_valid;
  logic       sensor_err;
  logic       busy;
  logic       sen_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int ov_cnt = 0;
  logic err_q = 1'b0;

  logic [7:0] m_tem;
  logic [7:0] m_hum;
  logic       m_err;

  assign dht_in = dht_oe ? 1'b0 : ~sen_low;

  dht11_temp_reader #(
    .CLK_HZ(1_000_000), .POLL_US(50), .START_US(20),
    .TIMEOUT_US(100), .BIT_THR_US(THR)
  ) dut (
    .clk(clk), .reset(reset), .dht_in(dht_in),
    .dht_oe(dht_oe), .tem_reg(tem_reg), .hum_reg(hum_reg),
    .data_valid(data_valid), .sensor_err(sensor_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (data_valid && sensor_err && !err_q) ov_cnt++;
    err_q = sensor_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk(input int h, input int hd,
      input int t, input int td, input int cadj);
    int c;
    c = (h + hd + t + td + cadj) % 256;
    return {8'(h), 8'(hd), 8'(t), 8'(td), 8'(c)};
  endfunction

  function automatic bit sum_ok(input logic [39:0] r);
    int s;
    s = int'(r[39:32]) + int'(r[31:24])
      + int'(r[23:16]) + int'(r[15:8]);
    return (s % 256) == int'(r[7:0]);
  endfunction

  task automatic hold(input logic lvl, input int n);
    sen_low = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(output int idle_n, output int oe_n);
    idle_n = 0;
    while (!dht_oe && idle_n < 300) begin
      @(negedge clk);
      idle_n++;
    end
    oe_n = 0;
    while (dht_oe && oe_n < 300) begin
      @(negedge clk);
      oe_n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_frame(input logic [39:0] f, input bit edge_w,
      input int nbits, output logic [39:0] rx);
    int w;
    rx = '0;
    hold(1'b0, $urandom_range(20, 40));
    hold(1'b1, $urandom_range(75, 85));
    hold(1'b0, $urandom_range(75, 85));
    for (int i = 39; i >= 40 - nbits; i--) begin
      if (edge_w) w = f[i] ? THR + 1 : THR;
      else w = f[i] ? $urandom_range(60, 75) : $urandom_range(20, 30);
      rx = {rx[38:0], (w > THR)};
      hold(1'b1, $urandom_range(45, 55));
      hold(1'b0, w);
    end
    if (nbits == 40) begin
      hold(1'b1, 50);
      sen_low = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [39:0] f, input bit edge_w,
                         input bit skip_start);
    int a, b, n, dv0, exp_dv;
    logic [39:0] rx;
    if (!skip_start) begin
      wait_start(a, b);
      chk("start_width", b, 20);
    end
    dv0 = dv_cnt;
    send_frame(f, edge_w, 40, rx);
    wait_idle(n);
    chk("txn_done", (n < 1000), 1);
    if (sum_ok(rx)) begin
      m_tem  = rx[23:16];
      m_hum  = rx[39:32];
      m_err  = 1'b0;
      exp_dv = 1;
    end else begin
      m_err  = 1'b1;
      exp_dv = 0;
    end
    chk("dv_pulses", dv_cnt - dv0, exp_dv);
    chk("tem", tem_reg, m_tem);
    chk("hum", hum_reg, m_hum);
    chk("err", sensor_err, m_err);
  endtask

  initial begin
    int a, b, n, dv0;
    logic [39:0] rx;
    m_tem = 8'd24;
    m_hum = 8'd0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tem", tem_reg, 24);
    chk("rst_hum", hum_reg, 0);
    chk("rst_oe", dht_oe, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_err", sensor_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    wait_start(a, b);
    chk("first_poll", (a >= 49 && a <= 51), 1);
    chk("start_width", b, 20);
    run_txn(mk(45, 0, 30, 0, 0), 1'b0, 1'b1);
    chk("good_tem30", tem_reg, 30);

    run_txn(mk(45, 0, 30, 0, 1), 1'b0, 1'b0);
    chk("bad_tem_hold", tem_reg, 30);

    wait_start(a, b);
    chk("start_width", b, 20);
    dv0 = dv_cnt;
    wait_idle(n);
    m_err = 1'b1;
    chk("silent_lat", (n >= 98 && n <= 106), 1);
    chk("silent_err", sensor_err, 1);
    chk("silent_tem", tem_reg, m_tem);
    chk("silent_dv", dv_cnt - dv0, 0);
    wait_start(a, b);
    chk("retry_poll", (a >= 49 && a <= 51), 1);
    chk("start_width", b, 20);
    run_txn(mk(50, 0, 22, 0, 0), 1'b0, 1'b1);

    run_txn(mk(8'h12, 0, 8'hA6, 1, 0), 1'b1, 1'b0);
    chk("bnd_tem", tem_reg, 8'hA6);
    chk("bnd_hum", hum_reg, 8'h12);

    run_txn(mk(0, 0, 0, 0, 0), 1'b0, 1'b0);
    chk("zero_tem", tem_reg, 0);

    for (int k = 0; k < 4; k++) begin
      run_txn(mk($urandom_range(20, 90), $urandom_range(0, 9),
                 $urandom_range(0, 50), $urandom_range(0, 9),
                 ($urandom_range(0, 3) == 0) ? 1 : 0),
              1'b0, 1'b0);
    end

    wait_start(a, b);
    send_frame(mk(60, 0, 33, 0, 0), 1'b0, 10, rx);
    hold(1'b1, 50);
    sen_low = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_oe", dht_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tem", tem_reg, 24);
    chk("mid_rst_hum", hum_reg, 0);
    m_tem = 8'd24;
    m_hum = 8'd0;
    m_err = 1'b0;
    hold(1'b0, 3);
    reset = 1'b0;
    wait_start(a, b);
    chk("post_rst_poll", (a >= 49 && a <= 51), 1);
    chk("start_width", b, 20);
    run_txn(mk(40, 0, 27, 0, 0), 1'b0, 1'b1);
    chk("post_rst_tem", tem_reg, 27);

    chk("dv_err_overlap", ov_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
